// File: rtl/hazard_ctrl_pkg.sv
// Shared core constants for the hazard controller: write-back select codes,
// zero register, PC stop levels and FSM state encodings.
package hazard_ctrl_pkg;

  localparam int WBSEL_W = 2;

  localparam logic [WBSEL_W-1:0] WBSEL_ALU = 2'd0;
  localparam logic [WBSEL_W-1:0] WBSEL_MEM = 2'd1;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic PC_STOP_ENABLE  = 1'b1;
  localparam logic PC_STOP_DISABLE = 1'b0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_mux.sv
// Forwarding mux for one D-stage operand: youngest matching producer wins,
// an optional override (multiply/divide completion) beats all producers.
module fwd_mux
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2
) (
  input  logic [4:0]              addr_src,
  input  logic [XLEN-1:0]         data_rf,
  input  logic [FWD_DEPTH-1:0]    reg_wen,
  input  logic [FWD_DEPTH*5-1:0]  addr_d,
  input  logic [FWD_DEPTH*XLEN-1:0] data_d,
  input  logic                    ovr_hit,
  input  logic [XLEN-1:0]         ovr_data,
  output logic [XLEN-1:0]         fwd_data
);

  // Oldest stage is visited first so younger matches overwrite it.
  always_comb begin
    fwd_data = data_rf;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (reg_wen[i] && (addr_d[i*5 +: 5] == addr_src)) begin
        fwd_data = data_d[i*XLEN +: XLEN];
      end
    end
    if (ovr_hit) begin
      fwd_data = ovr_data;
    end
    if (addr_src == ZERO_REG) begin
      fwd_data = data_rf;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding plus load-use stall FSM.
// Define HAZARD_MULDIV_EN to add the multiply/divide busy scoreboard.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_SRC*5-1:0]      AddrSrc_di,
  input  logic [NUM_SRC*XLEN-1:0]   DataSrc_di,
  input  logic [FWD_DEPTH-1:0]      RegWEn_si,
  input  logic [FWD_DEPTH*5-1:0]    AddrD_si,
  input  logic [FWD_DEPTH*XLEN-1:0] DataD_si,
  input  logic [WBSEL_W-1:0]        WBSel_ei,
  input  logic                      mem_ready_i,
`ifdef HAZARD_MULDIV_EN
  input  logic                      md_start_i,
  input  logic [4:0]                md_AddrD_i,
  input  logic                      md_done_i,
  input  logic [4:0]                md_AddrDone_i,
  input  logic [XLEN-1:0]           md_Data_i,
`endif
  output logic [NUM_SRC*XLEN-1:0]   DataSrc_do,
  output logic                      pc_stopFlag_o,
  output logic                      fd_hold_o,
  output logic                      de_flush_o,
  output logic [31:0]               stall_cnt_o
);

  hz_state_e           state_q, state_d;
  logic                load_use;
  logic                fsm_stall;
  logic                md_stall;
  logic                stall;
  logic [NUM_SRC-1:0]  md_hit;
  logic [XLEN-1:0]     md_data;
  logic [31:0]         stall_cnt_q;

  always_comb begin
    load_use = 1'b0;
    if ((WBSel_ei == WBSEL_MEM) && RegWEn_si[0] && (AddrD_si[4:0] != ZERO_REG)) begin
      for (int n = 0; n < NUM_SRC; n++) begin
        if (AddrSrc_di[n*5 +: 5] == AddrD_si[4:0]) begin
          load_use = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_use) state_d = LD_WAIT;
      LD_WAIT: if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fsm_stall = 1'b0;
    case (state_q)
      IDLE:    fsm_stall = load_use;
      LD_WAIT: fsm_stall = !mem_ready_i;
      default: fsm_stall = 1'b0;
    endcase
  end

`ifdef HAZARD_MULDIV_EN
  logic [31:1] busy_q;

  // Clear is applied before set so a same-cycle start on the address wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (md_start_i && (md_AddrD_i == 5'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (md_done_i && (md_AddrDone_i == 5'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    md_stall = 1'b0;
    md_hit   = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      md_hit[n] = md_done_i && (md_AddrDone_i == AddrSrc_di[n*5 +: 5])
                  && (AddrSrc_di[n*5 +: 5] != ZERO_REG);
      for (int r = 1; r < 32; r++) begin
        if (busy_q[r] && (AddrSrc_di[n*5 +: 5] == 5'(r)) && !md_hit[n]) begin
          md_stall = 1'b1;
        end
      end
    end
  end

  assign md_data = md_Data_i;
`else
  assign md_stall = 1'b0;
  assign md_hit   = '0;
  assign md_data  = '0;
`endif

  // Reset forces the stall outputs low even if a hazard pattern is present.
  assign stall = rst_n_i && (fsm_stall || md_stall);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign pc_stopFlag_o = stall ? PC_STOP_ENABLE : PC_STOP_DISABLE;
  assign fd_hold_o     = stall;
  assign de_flush_o    = stall;
  assign stall_cnt_o   = stall_cnt_q;

  generate
    for (genvar n = 0; n < NUM_SRC; n++) begin : g_fwd
      fwd_mux #(
        .XLEN      (XLEN),
        .FWD_DEPTH (FWD_DEPTH)
      ) u_fwd_mux (
        .addr_src (AddrSrc_di[n*5 +: 5]),
        .data_rf  (DataSrc_di[n*XLEN +: XLEN]),
        .reg_wen  (RegWEn_si),
        .addr_d   (AddrD_si),
        .data_d   (DataD_si),
        .ovr_hit  (md_hit[n]),
        .ovr_data (md_data),
        .fwd_data (DataSrc_do[n*XLEN +: XLEN])
      );
    end
  endgenerate

endmodule
